control_unit_legv8: RTL and testbench

- Multi-cycle LEGv8 control unit that drives the datapath's control word.
- Consumes the 32-bit instruction fetched from ROM and the registered status flags PRESTAT.
- Produces every datapath select and enable: register selects, ALU function, constant K, bus enables, PC control, RAM strobes and flag store.
- Sequences each instruction through FETCH/DECODE/EXEC(/MEM); halts on an undecodable instruction.

---
 rtl/legv8_ctrl_pkg.sv | 152 +++++++++++++++
 rtl/control_unit_legv8_cond_eval.sv | 37 +++
 rtl/control_unit_legv8.sv | 212 +++++++++++++++++++++
 tb/tb_control_unit_legv8.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/legv8_ctrl_pkg.sv
// Shared opcodes, ALU function codes, state codes and control word
// for the multi-cycle LEGv8 control unit.
package legv8_ctrl_pkg;

    localparam logic [10:0] OPC_ADD  = 11'b10001011000;
    localparam logic [10:0] OPC_ADDS = 11'b10101011000;
    localparam logic [10:0] OPC_SUB  = 11'b11001011000;
    localparam logic [10:0] OPC_SUBS = 11'b11101011000;
    localparam logic [10:0] OPC_AND  = 11'b10001010000;
    localparam logic [10:0] OPC_ORR  = 11'b10101010000;
    localparam logic [10:0] OPC_EOR  = 11'b11001010000;
    localparam logic [10:0] OPC_LDUR = 11'b11111000010;
    localparam logic [10:0] OPC_STUR = 11'b11111000000;

    localparam logic [9:0] OPC_ADDI = 10'b1001000100;
    localparam logic [9:0] OPC_SUBI = 10'b1101000100;
    localparam logic [9:0] OPC_ANDI = 10'b1001001000;
    localparam logic [9:0] OPC_ORRI = 10'b1011001000;

    localparam logic [5:0] OPC_B     = 6'b000101;
    localparam logic [7:0] OPC_CBZ   = 8'b10110100;
    localparam logic [7:0] OPC_CBNZ  = 8'b10110101;
    localparam logic [7:0] OPC_BCOND = 8'b01010100;

    // ALU_LEGv8: FS[4:2] selects AND/OR/ADD/XOR, FS[1] inverts B, FS[0] inverts A.
    // PASSA is OR against XZR on the B bus.
    localparam logic [4:0] FS_AND   = 5'b00000;
    localparam logic [4:0] FS_ORR   = 5'b00100;
    localparam logic [4:0] FS_ADD   = 5'b01000;
    localparam logic [4:0] FS_SUB   = 5'b01010;
    localparam logic [4:0] FS_EOR   = 5'b01100;
    localparam logic [4:0] FS_PASSA = 5'b00100;

    localparam logic [1:0] PS_HOLD = 2'b00;
    localparam logic [1:0] PS_INC  = 2'b01;
    localparam logic [1:0] PS_OFS  = 2'b10;

    localparam logic [2:0] ST_FETCH  = 3'd0;
    localparam logic [2:0] ST_DECODE = 3'd1;
    localparam logic [2:0] ST_EXEC   = 3'd2;
    localparam logic [2:0] ST_MEM    = 3'd3;
    localparam logic [2:0] ST_HALT   = 3'd4;

    localparam logic [4:0] XZR = 5'd31;

    typedef enum logic [3:0] {
        COND_EQ, COND_NE, COND_HS, COND_LO,
        COND_MI, COND_PL, COND_VS, COND_VC,
        COND_HI, COND_LS, COND_GE, COND_LT,
        COND_GT, COND_LE, COND_AL, COND_NV
    } cond_t;

    typedef enum logic [4:0] {
        OP_ILL, OP_ADD, OP_ADDS, OP_SUB, OP_SUBS,
        OP_AND, OP_ORR, OP_EOR, OP_ADDI, OP_SUBI,
        OP_ANDI, OP_ORRI, OP_LDUR, OP_STUR, OP_B,
        OP_CBZ, OP_CBNZ, OP_BCOND
    } op_t;

    typedef struct packed {
        logic [4:0]  sa;
        logic [4:0]  sb;
        logic [4:0]  da;
        logic        wr;
        logic [4:0]  fs;
        logic        c0;
        logic [63:0] k;
        logic        m;
        logic        en_alu;
        logic        en_addr_alu;
        logic        en_b;
        logic        pc_sel;
        logic [1:0]  ps;
        logic        rcs;
        logic        rwe;
        logic        roe;
        logic        sfl;
    } ctrl_t;

    function automatic op_t decode_op(input logic [31:0] ir);
        op_t op;
        op = OP_ILL;
        unique case (1'b1)
            ir[31:21] == OPC_ADD:   op = OP_ADD;
            ir[31:21] == OPC_ADDS:  op = OP_ADDS;
            ir[31:21] == OPC_SUB:   op = OP_SUB;
            ir[31:21] == OPC_SUBS:  op = OP_SUBS;
            ir[31:21] == OPC_AND:   op = OP_AND;
            ir[31:21] == OPC_ORR:   op = OP_ORR;
            ir[31:21] == OPC_EOR:   op = OP_EOR;
            ir[31:21] == OPC_LDUR:  op = OP_LDUR;
            ir[31:21] == OPC_STUR:  op = OP_STUR;
            ir[31:22] == OPC_ADDI:  op = OP_ADDI;
            ir[31:22] == OPC_SUBI:  op = OP_SUBI;
            ir[31:22] == OPC_ANDI:  op = OP_ANDI;
            ir[31:22] == OPC_ORRI:  op = OP_ORRI;
            ir[31:26] == OPC_B:     op = OP_B;
            ir[31:24] == OPC_CBZ:   op = OP_CBZ;
            ir[31:24] == OPC_CBNZ:  op = OP_CBNZ;
            ir[31:24] == OPC_BCOND: op = OP_BCOND;
            default:                op = OP_ILL;
        endcase
        return op;
    endfunction

    function automatic logic is_alu(input op_t op);
        return op inside {OP_ADD, OP_ADDS, OP_SUB, OP_SUBS, OP_AND,
                          OP_ORR, OP_EOR, OP_ADDI, OP_SUBI, OP_ANDI, OP_ORRI};
    endfunction

    function automatic logic is_itype(input op_t op);
        return op inside {OP_ADDI, OP_SUBI, OP_ANDI, OP_ORRI};
    endfunction

    function automatic logic is_sub(input op_t op);
        return op inside {OP_SUB, OP_SUBS, OP_SUBI};
    endfunction

    function automatic logic sets_flags(input op_t op);
        return op inside {OP_ADDS, OP_SUBS};
    endfunction

    function automatic logic is_cb(input op_t op);
        return op inside {OP_CBZ, OP_CBNZ};
    endfunction

    function automatic logic [4:0] alu_fs(input op_t op);
        logic [4:0] fs;
        fs = FS_ADD;
        unique case (op)
            OP_SUB, OP_SUBS, OP_SUBI: fs = FS_SUB;
            OP_AND, OP_ANDI:          fs = FS_AND;
            OP_ORR, OP_ORRI:          fs = FS_ORR;
            OP_EOR:                   fs = FS_EOR;
            default:                  fs = FS_ADD;
        endcase
        return fs;
    endfunction

    function automatic logic [63:0] sext9(input logic [8:0] v);
        return {{55{v[8]}}, v};
    endfunction

    function automatic logic [63:0] sext19(input logic [18:0] v);
        return {{45{v[18]}}, v};
    endfunction

    function automatic logic [63:0] sext26(input logic [25:0] v);
        return {{38{v[25]}}, v};
    endfunction

endpackage

// File: rtl/control_unit_legv8_cond_eval.sv
// Branch condition evaluator: 4-bit condition code against
// registered flags {N,Z,C,V}.
module cond_eval
    import legv8_ctrl_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       taken
);

    logic n, z, c, v;

    assign {n, z, c, v} = flags;

    always_comb begin
        taken = 1'b0;
        unique case (cond_t'(cond))
            COND_EQ: taken = z;
            COND_NE: taken = !z;
            COND_HS: taken = c;
            COND_LO: taken = !c;
            COND_MI: taken = n;
            COND_PL: taken = !n;
            COND_VS: taken = v;
            COND_VC: taken = !v;
            COND_HI: taken = c && !z;
            COND_LS: taken = !(c && !z);
            COND_GE: taken = (n == v);
            COND_LT: taken = (n != v);
            COND_GT: taken = !z && (n == v);
            COND_LE: taken = !(!z && (n == v));
            COND_AL: taken = 1'b1;
            COND_NV: taken = 1'b1;
        endcase
    end

endmodule

// File: rtl/control_unit_legv8.sv
// Multi-cycle LEGv8 control unit: FETCH/DECODE/EXEC(/MEM) sequencer
// producing the full datapath control word.
module control_unit_legv8
    import legv8_ctrl_pkg::*;
#(
    parameter bit HALT_ON_ILLEGAL = 1'b1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] inst,
    input  logic [3:0]  PRESTAT,
    output logic [4:0]  SA,
    output logic [4:0]  SB,
    output logic [4:0]  DA,
    output logic        WR,
    output logic [4:0]  FS,
    output logic        C0,
    output logic [63:0] K,
    output logic        M,
    output logic        EN_ALU,
    output logic        EN_ADDR_ALU,
    output logic        EN_B,
    output logic        EN_PC,
    output logic        EN_ADDR_PC,
    output logic        PC_SEL,
    output logic [1:0]  PS,
    output logic        RCS,
    output logic        RWE,
    output logic        ROE,
    output logic        SFL,
    output logic        halted,
    output logic [2:0]  state_dbg
);

    logic [2:0]  state, state_nxt;
    logic [31:0] ir;
    logic        cnt, cnt_nxt;
    op_t         op;
    logic        cond_taken;
    logic        cb_taken;
    ctrl_t       c;
    ctrl_t       q;

    logic [4:0]  rd, rn, rm;
    logic [11:0] imm12;
    logic [8:0]  imm9;
    logic [18:0] imm19;
    logic [25:0] imm26;

    assign rd    = ir[4:0];
    assign rn    = ir[9:5];
    assign rm    = ir[20:16];
    assign imm12 = ir[21:10];
    assign imm9  = ir[20:12];
    assign imm19 = ir[23:5];
    assign imm26 = ir[25:0];

    assign op = decode_op(ir);

    cond_eval u_cond (
        .cond  (ir[3:0]),
        .flags (PRESTAT),
        .taken (cond_taken)
    );

    // Second CB pass sees the Z flag left by the PASSA pass.
    assign cb_taken = (op == OP_CBZ) ? PRESTAT[2] : !PRESTAT[2];

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= ST_FETCH;
            ir    <= '0;
            cnt   <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (state == ST_FETCH) ir <= inst;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = 1'b0;
        unique case (state)
            ST_FETCH:  state_nxt = ST_DECODE;
            ST_DECODE: begin
                if (op != OP_ILL)        state_nxt = ST_EXEC;
                else if (HALT_ON_ILLEGAL) state_nxt = ST_HALT;
                else                     state_nxt = ST_FETCH;
            end
            ST_EXEC: begin
                state_nxt = ST_FETCH;
                if (op == OP_LDUR) begin
                    state_nxt = ST_MEM;
                end else if (is_cb(op) && !cnt) begin
                    state_nxt = ST_EXEC;
                    cnt_nxt   = 1'b1;
                end
            end
            ST_MEM:    state_nxt = ST_FETCH;
            ST_HALT:   state_nxt = ST_HALT;
            default:   state_nxt = ST_FETCH;
        endcase
    end

    always_comb begin
        c = '0;
        unique case (state)
            ST_DECODE: begin
                if (op == OP_ILL && !HALT_ON_ILLEGAL) c.ps = PS_INC;
            end
            ST_EXEC: begin
                if (is_alu(op)) begin
                    c.sa     = rn;
                    c.da     = rd;
                    c.wr     = (rd != XZR);
                    c.fs     = alu_fs(op);
                    c.c0     = is_sub(op);
                    c.sfl    = sets_flags(op);
                    c.en_alu = 1'b1;
                    c.ps     = PS_INC;
                    if (is_itype(op)) begin
                        c.m = 1'b1;
                        c.k = {52'd0, imm12};
                    end else begin
                        c.sb = rm;
                    end
                end
                unique case (op)
                    OP_LDUR, OP_STUR: begin
                        c.sa          = rn;
                        c.m           = 1'b1;
                        c.k           = sext9(imm9);
                        c.fs          = FS_ADD;
                        c.en_addr_alu = 1'b1;
                        c.rcs         = 1'b1;
                        if (op == OP_STUR) begin
                            c.sb   = rd;
                            c.en_b = 1'b1;
                            c.rwe  = 1'b1;
                            c.ps   = PS_INC;
                        end else begin
                            c.roe = 1'b1;
                        end
                    end
                    OP_B: begin
                        c.pc_sel = 1'b1;
                        c.k      = sext26(imm26);
                        c.ps     = PS_OFS;
                    end
                    OP_BCOND: begin
                        c.k      = sext19(imm19);
                        c.pc_sel = cond_taken;
                        c.ps     = cond_taken ? PS_OFS : PS_INC;
                    end
                    OP_CBZ, OP_CBNZ: begin
                        if (!cnt) begin
                            c.sa  = rd;
                            c.sb  = XZR;
                            c.fs  = FS_PASSA;
                            c.sfl = 1'b1;
                        end else begin
                            c.k      = sext19(imm19);
                            c.pc_sel = cb_taken;
                            c.ps     = cb_taken ? PS_OFS : PS_INC;
                        end
                    end
                    default: ;
                endcase
            end
            ST_MEM: begin
                c.sa          = rn;
                c.m           = 1'b1;
                c.k           = sext9(imm9);
                c.fs          = FS_ADD;
                c.en_addr_alu = 1'b1;
                c.rcs         = 1'b1;
                c.roe         = 1'b1;
                c.da          = rd;
                c.wr          = (rd != XZR);
                c.ps          = PS_INC;
            end
            default: ;
        endcase
    end

    // Strobes drop while RST is high, before the state register clears.
    assign q = RST ? '0 : c;

    assign SA          = q.sa;
    assign SB          = q.sb;
    assign DA          = q.da;
    assign WR          = q.wr;
    assign FS          = q.fs;
    assign C0          = q.c0;
    assign K           = q.k;
    assign M           = q.m;
    assign EN_ALU      = q.en_alu;
    assign EN_ADDR_ALU = q.en_addr_alu;
    assign EN_B        = q.en_b;
    assign EN_PC       = 1'b0;
    assign EN_ADDR_PC  = 1'b0;
    assign PC_SEL      = q.pc_sel;
    assign PS          = q.ps;
    assign RCS         = q.rcs;
    assign RWE         = q.rwe;
    assign ROE         = q.roe;
    assign SFL         = q.sfl;
    assign halted      = (state == ST_HALT);
    assign state_dbg   = state;

endmodule

// File: tb/tb_control_unit_legv8.sv
// Directed-vector bench for control_unit_legv8 with an
// instruction-level reference model and per-cycle compare.
module tb_control_unit_legv8;

    logic        CLK = 1'b0;
    logic        RST;
    logic [31:0] inst;
    logic [3:0]  PRESTAT;
    logic [4:0]  SA, SB, DA, FS;
    logic        WR, C0, M, EN_ALU, EN_ADDR_ALU, EN_B, EN_PC;
    logic        EN_ADDR_PC, PC_SEL, RCS, RWE, ROE, SFL, halted;
    logic [63:0] K;
    logic [1:0]  PS;
    logic [2:0]  state_dbg;

    control_unit_legv8 dut (
        .CLK(CLK), .RST(RST), .inst(inst), .PRESTAT(PRESTAT),
        .SA(SA), .SB(SB), .DA(DA), .WR(WR), .FS(FS), .C0(C0),
        .K(K), .M(M), .EN_ALU(EN_ALU), .EN_ADDR_ALU(EN_ADDR_ALU),
        .EN_B(EN_B), .EN_PC(EN_PC), .EN_ADDR_PC(EN_ADDR_PC),
        .PC_SEL(PC_SEL), .PS(PS), .RCS(RCS), .RWE(RWE), .ROE(ROE),
        .SFL(SFL), .halted(halted), .state_dbg(state_dbg)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [4:0]  sa, sb, da;
        logic        wr;
        logic [4:0]  fs;
        logic        c0;
        logic [63:0] k;
        logic        m, en_alu, en_addr_alu, en_b, en_pc, en_addr_pc, pc_sel;
        logic [1:0]  ps;
        logic        rcs, rwe, roe, sfl, halted;
        logic [2:0]  st;
    } cw_t;

    cw_t got;
    assign got = {SA, SB, DA, WR, FS, C0, K, M, EN_ALU, EN_ADDR_ALU, EN_B,
                  EN_PC, EN_ADDR_PC, PC_SEL, PS, RCS, RWE, ROE, SFL,
                  halted, state_dbg};

    localparam int K_ILL = 0, K_ADD = 1, K_ADDS = 2, K_SUB = 3, K_SUBS = 4;
    localparam int K_AND = 5, K_ORR = 6, K_EOR = 7, K_ADDI = 8, K_SUBI = 9;
    localparam int K_ANDI = 10, K_ORRI = 11, K_LDUR = 12, K_STUR = 13;
    localparam int K_B = 14, K_CBZ = 15, K_CBNZ = 16, K_BCOND = 17;

    int checks = 0;
    int errors = 0;

    logic [31:0] cur_inst = '0;
    int          cur_phase = 0;
    bit          chk_en = 1'b0;
    cw_t         snap [4];

    function automatic int classify(input logic [31:0] i);
        casez (i[31:21])
            11'b10001011000: return K_ADD;
            11'b10101011000: return K_ADDS;
            11'b11001011000: return K_SUB;
            11'b11101011000: return K_SUBS;
            11'b10001010000: return K_AND;
            11'b10101010000: return K_ORR;
            11'b11001010000: return K_EOR;
            11'b1001000100?: return K_ADDI;
            11'b1101000100?: return K_SUBI;
            11'b1001001000?: return K_ANDI;
            11'b1011001000?: return K_ORRI;
            11'b11111000010: return K_LDUR;
            11'b11111000000: return K_STUR;
            11'b000101?????: return K_B;
            11'b10110100???: return K_CBZ;
            11'b10110101???: return K_CBNZ;
            11'b01010100???: return K_BCOND;
            default:         return K_ILL;
        endcase
    endfunction

    function automatic int inst_len(input logic [31:0] i);
        int k;
        k = classify(i);
        if (k == K_ILL) return 2;
        if (k == K_LDUR || k == K_CBZ || k == K_CBNZ) return 4;
        return 3;
    endfunction

    function automatic logic [63:0] simm(input logic [31:0] v, input int w);
        longint x;
        x = longint'(v);
        if (v[w-1]) x = x - (longint'(1) <<< w);
        return x;
    endfunction

    function automatic logic [4:0] fs_for(input int k);
        case (k)
            K_SUB, K_SUBS, K_SUBI: return 5'b01010;
            K_AND, K_ANDI:         return 5'b00000;
            K_ORR, K_ORRI:         return 5'b00100;
            K_EOR:                 return 5'b01100;
            default:               return 5'b01000;
        endcase
    endfunction

    // ARM rule: odd codes invert the even base, except 1111 (always).
    function automatic bit cond_holds(input logic [3:0] cc, input logic [3:0] f);
        bit n, z, c, v, base;
        {n, z, c, v} = f;
        case (cc[3:1])
            3'd0:    base = z;
            3'd1:    base = c;
            3'd2:    base = n;
            3'd3:    base = v;
            3'd4:    base = c && !z;
            3'd5:    base = (n == v);
            3'd6:    base = !z && (n == v);
            default: base = 1'b1;
        endcase
        return (cc[0] && cc != 4'hF) ? !base : base;
    endfunction

    // phase: 0 fetch, 1 decode, 2 exec, 3 mem / second CB pass, 9 halt
    function automatic cw_t model(input logic [31:0] i, input int p,
                                  input logic [3:0] f);
        cw_t e;
        int  k;
        bit  tk;
        e = '0;
        k = classify(i);
        if (p == 9) begin
            e.halted = 1'b1;
            e.st     = 3'd4;
            return e;
        end
        if (p < 2) begin
            e.st = 3'(p);
            return e;
        end
        e.st = (p == 3 && k == K_LDUR) ? 3'd3 : 3'd2;
        if (k >= K_ADD && k <= K_ORRI) begin
            e.sa     = i[9:5];
            e.da     = i[4:0];
            e.wr     = (i[4:0] != 5'd31);
            e.en_alu = 1'b1;
            e.ps     = 2'b01;
            e.fs     = fs_for(k);
            e.c0     = (k == K_SUB || k == K_SUBS || k == K_SUBI);
            e.sfl    = (k == K_ADDS || k == K_SUBS);
            if (k >= K_ADDI) begin
                e.m = 1'b1;
                e.k = 64'(i[21:10]);
            end else begin
                e.sb = i[20:16];
            end
        end else if (k == K_LDUR || k == K_STUR) begin
            e.sa          = i[9:5];
            e.m           = 1'b1;
            e.k           = simm(32'(i[20:12]), 9);
            e.fs          = 5'b01000;
            e.en_addr_alu = 1'b1;
            e.rcs         = 1'b1;
            if (k == K_STUR) begin
                e.sb   = i[4:0];
                e.en_b = 1'b1;
                e.rwe  = 1'b1;
                e.ps   = 2'b01;
            end else begin
                e.roe = 1'b1;
                if (p == 3) begin
                    e.da = i[4:0];
                    e.wr = (i[4:0] != 5'd31);
                    e.ps = 2'b01;
                end
            end
        end else if (k == K_B) begin
            e.pc_sel = 1'b1;
            e.k      = simm(32'(i[25:0]), 26);
            e.ps     = 2'b10;
        end else if (k == K_BCOND) begin
            tk       = cond_holds(i[3:0], f);
            e.k      = simm(32'(i[23:5]), 19);
            e.pc_sel = tk;
            e.ps     = tk ? 2'b10 : 2'b01;
        end else if (k == K_CBZ || k == K_CBNZ) begin
            if (p == 2) begin
                e.sa  = i[4:0];
                e.sb  = 5'd31;
                e.fs  = 5'b00100;
                e.sfl = 1'b1;
            end else begin
                tk       = (k == K_CBZ) ? f[2] : !f[2];
                e.k      = simm(32'(i[23:5]), 19);
                e.pc_sel = tk;
                e.ps     = tk ? 2'b10 : 2'b01;
            end
        end
        return e;
    endfunction

    always @(negedge CLK) begin
        if (chk_en) begin
            cw_t e;
            e = model(cur_inst, cur_phase, PRESTAT);
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL cw inst=%h phase=%0d got=%h exp=%h",
                         cur_inst, cur_phase, got, e);
            end
        end
    end

    task automatic lit(input string name, input logic [63:0] g,
                       input logic [63:0] x);
        checks++;
        if (g !== x) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, g, x);
        end
    endtask

    task automatic run_inst(input logic [31:0] i, input logic [3:0] f_ex,
                            input logic [3:0] f_late);
        int n;
        n = inst_len(i);
        for (int p = 0; p < n; p++) begin
            cur_inst  = i;
            cur_phase = p;
            inst      = (p == 0) ? i : ~i;
            PRESTAT   = (p >= 3) ? f_late : f_ex;
            chk_en    = 1'b1;
            @(negedge CLK);
            snap[p] = got;
            @(posedge CLK);
            #1;
        end
        chk_en = 1'b0;
    endtask

    logic [3:0] fl [7] = '{4'b0000, 4'b0100, 4'b0010, 4'b1000,
                           4'b0001, 4'b1001, 4'b0110};

    initial begin
        RST     = 1'b1;
        inst    = '0;
        PRESTAT = '0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        lit("rst_state", got.st, 3'd0);
        lit("rst_halted", got.halted, 1'b0);
        lit("rst_ps_strobes", {got.ps, got.rcs, got.rwe, got.wr, got.en_alu}, '0);
        @(posedge CLK);
        #1;
        RST = 1'b0;

        run_inst(32'h8B020023, 4'b0000, 4'b0000);
        lit("add_sa", snap[2].sa, 5'd1);
        lit("add_sb", snap[2].sb, 5'd2);
        lit("add_da_wr", {snap[2].da, snap[2].wr}, {5'd3, 1'b1});
        lit("add_ctl", {snap[2].en_alu, snap[2].m, snap[2].sfl, snap[2].ps},
            {1'b1, 1'b0, 1'b0, 2'b01});
        lit("add_fs", snap[2].fs, 5'b01000);

        run_inst(32'h8B02003F, 4'b0000, 4'b0000);
        lit("add_x31_wr", snap[2].wr, 1'b0);

        run_inst(32'hEB0600A4, 4'b0000, 4'b0000);
        lit("subs_c0_sfl", {snap[2].c0, snap[2].sfl}, 2'b11);

        run_inst(32'h913FFC27, 4'b0000, 4'b0000);
        lit("addi_k", snap[2].k, 64'h0FFF);
        lit("addi_m", snap[2].m, 1'b1);

        run_inst(32'h8A030041, 4'b0000, 4'b0000);
        run_inst(32'hAA030041, 4'b0000, 4'b0000);
        run_inst(32'hCA030041, 4'b0000, 4'b0000);
        run_inst(32'hCB030041, 4'b0000, 4'b0000);
        run_inst(32'hAB030041, 4'b0000, 4'b0000);
        run_inst(32'hD1001441, 4'b0000, 4'b0000);
        run_inst(32'h92001441, 4'b0000, 4'b0000);
        run_inst(32'hB2001441, 4'b0000, 4'b0000);

        run_inst(32'hF8408025, 4'b0000, 4'b0000);
        lit("ldur_k", snap[2].k, 64'd8);
        lit("ldur_strobes", {snap[2].rcs, snap[2].roe, snap[2].en_addr_alu,
            snap[2].m, snap[2].ps}, {4'b1111, 2'b00});
        lit("ldur_mem", {snap[3].da, snap[3].wr, snap[3].ps, snap[3].st},
            {5'd5, 1'b1, 2'b01, 3'd3});

        run_inst(32'hF81F0062, 4'b0000, 4'b0000);
        lit("stur_k", snap[2].k, 64'hFFFF_FFFF_FFFF_FFF0);
        lit("stur_rwe_b", {snap[2].rwe, snap[2].en_b, snap[2].sb}, {2'b11, 5'd2});

        run_inst(32'h54000080, 4'b0100, 4'b0000);
        lit("beq_taken", {snap[2].ps, snap[2].pc_sel, snap[2].k},
            {2'b10, 1'b1, 64'd4});
        run_inst(32'h54000080, 4'b0000, 4'b0000);
        lit("beq_not", {snap[2].ps, snap[2].pc_sel}, {2'b01, 1'b0});
        run_inst(32'h5400008A, 4'b1000, 4'b0000);
        lit("bge_nv_diff", snap[2].ps, 2'b01);

        run_inst(32'h17FFFFF8, 4'b0000, 4'b0000);
        lit("b_k", snap[2].k, 64'hFFFF_FFFF_FFFF_FFF8);
        lit("b_ps", {snap[2].ps, snap[2].pc_sel}, {2'b10, 1'b1});

        for (int cc = 0; cc < 16; cc++)
            for (int fi = 0; fi < 7; fi++)
                run_inst(32'h54FFFFA0 | 32'(cc), fl[fi], 4'b0000);

        run_inst(32'hB4000069, 4'b0000, 4'b0100);
        lit("cbz_pass", {snap[2].sa, snap[2].sfl}, {5'd9, 1'b1});
        lit("cbz_taken", {snap[3].ps, snap[3].k, snap[3].st},
            {2'b10, 64'd3, 3'd2});
        run_inst(32'hB5000069, 4'b0000, 4'b0100);
        lit("cbnz_not", {snap[3].ps, snap[3].pc_sel}, {2'b01, 1'b0});
        run_inst(32'hB5000069, 4'b0000, 4'b0000);
        run_inst(32'hB4000069, 4'b0000, 4'b0000);

        // reset raised mid-EXEC of a store must kill RWE immediately
        inst = 32'hF81F0062;
        @(posedge CLK);
        #1;
        inst = ~inst;
        @(posedge CLK);
        #1;
        @(negedge CLK);
        lit("stur_rwe_pre", got.rwe, 1'b1);
        #1;
        RST = 1'b1;
        #1;
        lit("rst_drops_rwe", {got.rwe, got.rcs, got.en_b, got.ps}, '0);
        @(posedge CLK);
        #1;
        RST = 1'b0;
        run_inst(32'h8B020023, 4'b0000, 4'b0000);

        run_inst(32'h00000000, 4'b0000, 4'b0000);
        for (int j = 0; j < 5; j++) begin
            cur_phase = 9;
            cur_inst  = 32'h0;
            inst      = $urandom;
            chk_en    = 1'b1;
            @(negedge CLK);
            snap[0] = got;
            @(posedge CLK);
            #1;
        end
        chk_en = 1'b0;
        lit("halt_flag", snap[0].halted, 1'b1);
        lit("halt_state", snap[0].st, 3'd4);
        RST = 1'b1;
        @(negedge CLK);
        lit("halt_rst_strobes", {got.ps, got.wr, got.rcs, got.en_alu}, '0);
        @(posedge CLK);
        #1;
        RST = 1'b0;
        run_inst(32'h8B020023, 4'b0000, 4'b0000);
        lit("post_halt_fetch", {snap[0].halted, snap[0].st}, 4'b0000);
        lit("post_halt_add", snap[2].da, 5'd3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
